tick_timer_ctrl: RTL and testbench
==================================

// Module: tick_timer_ctrl
// PURPOSE
// - Programmable timer controller built on a modulo-M prescaler: sequences the prescaler and counts N ticks.
// - Gives the Simplez peripheral bus start/stop/busy/done control instead of a free-running divider.
// - Provides one-shot and periodic delays in whole prescaler periods (M=1200000 -> 100 ms at 12 MHz).
// PARAMETERS
// - M   1200000  prescaler period in clk cycles (>=2); tick_out period while running
// - W   8        width of tick count / remaining count
// PORTS
// - clk        in   1  system clock (12 MHz iceStick)
// - rst        in   1  reset, synchronous, active-high
// - start      in   1  1-cycle request: load count, restart prescaler, enter RUN
// - stop       in   1  1-cycle request: abort, return to IDLE, no done
// - count      in   W  number of ticks N to wait; sampled only when start=1
// - periodic   in   1  sampled with start; 1 = auto-reload after each expiry
// - busy       out  1  1 while in RUN
// - done       out  1  registered 1-cycle pulse on expiry
// - tick_out   out  1  1-cycle pulse each prescaler wrap while RUN; 0 in IDLE
// - remaining  out  W  ticks still to elapse in current period; 0 in IDLE
// BEHAVIOUR
// - Reset (rst=1 at a clk edge): state=IDLE, prescaler=0, remaining=0, reload=0, mode=one-shot; busy=done=tick_out=0.
// - State machine: IDLE, RUN. done is a registered pulse, not a state.
// - Prescaler: ceil(log2 M)-bit counter, counts 0..M-1 only in RUN, wraps to 0; tick = RUN && presc==M-1.
// - IDLE + start, count>=1: -> RUN; presc<=0, remaining<=count, reload<=count, mode<=periodic.
// - IDLE + start, count==0: stay IDLE; done=1 next cycle (zero delay).
// - RUN + tick: remaining<=remaining-1; tick_out=1 that cycle (combinational from presc).
// - RUN + tick with remaining==1: done<=1 (high in following cycle);
//   one-shot -> IDLE, remaining<=0; periodic -> stay RUN, remaining<=reload, presc wraps.
// - Latency: start sampled at edge k, N>=1 -> done high in cycle after edge k+N*M; busy high from edge k+1.
// - Periodic: done every N*M cycles, no gap; prescaler never stalls at reload.
// - start while RUN: retrigger -- same actions as from IDLE; pending expiry that cycle suppressed (no done).
// - stop while RUN: -> IDLE, remaining<=0, presc<=0, no done, no tick_out that cycle.
// - start and stop same cycle: stop wins.
// - stop in IDLE: no effect.
// - rst has priority over start/stop; rst mid-RUN aborts with no done pulse.
// - Arithmetic: remaining never underflows (decrement only when >=1); count max 2^W-1.
// CONFIGURATION
// - Macro TICK_TIMER_IRQ_EN:
//   defined -> extra ports irq (out,1) and irq_ack (in,1); irq set on every done pulse, held until irq_ack=1;
//     set and ack same cycle -> irq stays 1; rst clears irq.
//   undefined -> ports irq/irq_ack absent; only the done pulse signals expiry.
// TESTING (bench uses M=4, W=8)
// - rst held 2 cycles -> busy=done=tick_out=0, remaining=0 after reset.
// - start, count=3, periodic=0 -> busy next cycle; tick_out pulses every 4 cycles;
//   remaining 3->2->1->0; done exactly 12 cycles after start edge, busy=0 after.
// - start, count=2, periodic=1 -> done pulses at +8, +16, +24; busy stays 1; stop -> busy=0, no further done.
// - start, count=0 -> done=1 next cycle, busy never asserted.
// - count=5 running, start with count=1 at cycle 10 -> original expiry never occurs;
//   done 4 cycles after retrigger; start+stop same cycle -> IDLE, no done.
// - TICK_TIMER_IRQ_EN defined: one-shot count=1 -> irq rises with done, holds; irq_ack -> irq=0 next cycle.

Source files
------------

// File: rtl/tick_timer_if.sv
// Bus bundle between a Simplez peripheral master and tick_timer_ctrl.
// Optional irq/irq_ack pair is present only when TICK_TIMER_IRQ_EN is defined.
interface tick_timer_if #(
  parameter int unsigned W = 8
) ();
  logic         start;
  logic         stop;
  logic [W-1:0] count;
  logic         periodic;
  logic         busy;
  logic         done;
  logic         tick_out;
  logic [W-1:0] remaining;
`ifdef TICK_TIMER_IRQ_EN
  logic         irq;
  logic         irq_ack;
`endif

  modport master (
    output start,
    output stop,
    output count,
    output periodic,
`ifdef TICK_TIMER_IRQ_EN
    output irq_ack,
    input  irq,
`endif
    input  busy,
    input  done,
    input  tick_out,
    input  remaining
  );

  modport slave (
    input  start,
    input  stop,
    input  count,
    input  periodic,
`ifdef TICK_TIMER_IRQ_EN
    input  irq_ack,
    output irq,
`endif
    output busy,
    output done,
    output tick_out,
    output remaining
  );
endinterface

// File: rtl/tick_timer_ctrl.sv
// Programmable one-shot/periodic timer: modulo-M prescaler sequenced to count N ticks.
// Define TICK_TIMER_IRQ_EN to add a sticky irq output with irq_ack clear.
module tick_timer_ctrl #(
  parameter int unsigned M = 1200000,
  parameter int unsigned W = 8
) (
  input  logic        clk,
  input  logic        rst,
  tick_timer_if.slave bus
);

  localparam int unsigned PW = (M > 1) ? $clog2(M) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(M - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  remaining_q, remaining_d;
  logic [W-1:0]  reload_q, reload_d;
  logic          periodic_q, periodic_d;
  logic          done_q, done_d;
  logic          tick;

  assign tick = (state_q == StRun) && (presc_q == PrescLast);

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    remaining_d = remaining_q;
    reload_d    = reload_q;
    periodic_d  = periodic_q;
    done_d      = 1'b0;

    if (bus.stop) begin
      // Stop beats a simultaneous start; in IDLE this leaves everything as is.
      if (state_q == StRun) begin
        state_d     = StIdle;
        presc_d     = '0;
        remaining_d = '0;
      end
    end else if (bus.start) begin
      presc_d = '0;
      if (bus.count != '0) begin
        state_d     = StRun;
        remaining_d = bus.count;
        reload_d    = bus.count;
        periodic_d  = bus.periodic;
      end else begin
        state_d     = StIdle;
        remaining_d = '0;
        done_d      = 1'b1;
      end
    end else if (state_q == StRun) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (remaining_q == W'(1)) begin
          done_d = 1'b1;
          if (periodic_q) begin
            remaining_d = reload_q;
          end else begin
            state_d     = StIdle;
            remaining_d = '0;
          end
        end else if (remaining_q != '0) begin
          remaining_d = remaining_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      remaining_q <= '0;
      reload_q    <= '0;
      periodic_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      remaining_q <= remaining_d;
      reload_q    <= reload_d;
      periodic_q  <= periodic_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = (state_q == StRun);
  assign bus.done      = done_q;
  assign bus.tick_out  = tick && !bus.stop;
  assign bus.remaining = remaining_q;

`ifdef TICK_TIMER_IRQ_EN
  logic irq_q, irq_d;

  // Set wins over a same-cycle ack so no expiry is lost.
  assign irq_d = done_d || (irq_q && !bus.irq_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Self-checking bench for tick_timer_ctrl (M=4, W=8): directed table, corner sequences,
// and random traffic against an elapsed-time reference model.
module tb_tick_timer_ctrl;
  localparam int unsigned M = 4;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tick_timer_if #(.W(W)) bus ();

  tick_timer_ctrl #(.M(M), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: elapsed cycles since the last (re)start, ticks derived arithmetically.
  bit m_run;
  bit m_per;
  int m_n;
  int m_t;
  bit m_done;
  bit m_irq;

  typedef struct {
    logic       start;
    logic       stop;
    logic       per;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       tick;
    logic [7:0] rem;
  } vec_t;

  vec_t vt[$];
  int   dq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic sp, input logic [7:0] cnt, input logic per,
                       input logic ack);
    bus.start    = st;
    bus.stop     = sp;
    bus.count    = cnt;
    bus.periodic = per;
`ifdef TICK_TIMER_IRQ_EN
    bus.irq_ack  = ack;
`else
    if (ack) begin end
`endif
  endtask

  task automatic check_model();
    chk("busy", bus.busy, m_run);
    chk("done", bus.done, m_done);
    chk("tick_out", bus.tick_out, m_run && (m_t % M == M - 1) && !bus.stop);
    chk("remaining", bus.remaining, m_run ? (m_n - ((m_t / M) % m_n)) : 0);
`ifdef TICK_TIMER_IRQ_EN
    chk("irq", bus.irq, m_irq);
`endif
  endtask

  task automatic model_update();
    bit ack;
`ifdef TICK_TIMER_IRQ_EN
    ack = bus.irq_ack;
`else
    ack = 1'b0;
`endif
    if (rst) begin
      m_run = 0; m_done = 0; m_irq = 0; m_t = 0; m_n = 1; m_per = 0;
      return;
    end
    m_done = 0;
    if (bus.stop) begin
      m_run = 0;
    end else if (bus.start) begin
      if (bus.count != 0) begin
        m_run = 1; m_t = 0; m_n = int'(bus.count); m_per = bus.periodic;
      end else begin
        m_run = 0; m_done = 1;
      end
    end else if (m_run) begin
      m_t++;
      if (m_t % (m_n * M) == 0) begin
        m_done = 1;
        if (!m_per) m_run = 0;
      end
    end
    m_irq = m_done || (m_irq && !ack);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // Drive, settle, compare against the model, leave the edge to the caller.
  task automatic apply(input logic st, input logic sp, input logic [7:0] cnt, input logic per,
                       input logic ack);
    drive(st, sp, cnt, per, ack);
    #1;
    check_model();
  endtask

  task automatic add(input logic st, input logic sp, input logic [7:0] cnt, input logic per,
                     input logic b, input logic d, input logic t, input logic [7:0] r);
    vec_t v;
    v.start = st; v.stop = sp; v.count = cnt; v.per = per;
    v.busy = b; v.done = d; v.tick = t; v.rem = r;
    vt.push_back(v);
  endtask

  initial begin
    int cnt;
    // Directed table: reset state, one-shot N=3, zero-count start.
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 3, 0, 0, 0, 0, 0);
    for (int r = 1; r <= 12; r++) begin
      add(0, 0, 0, 0, 1, 0, (r % 4 == 0), 8'(3 - (r - 1) / 4));
    end
    add(0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);

    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    advance();
    advance();
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].start, vt[i].stop, vt[i].count, vt[i].per, 0);
      #1;
      chk($sformatf("vec%0d_busy", i), bus.busy, vt[i].busy);
      chk($sformatf("vec%0d_done", i), bus.done, vt[i].done);
      chk($sformatf("vec%0d_tick", i), bus.tick_out, vt[i].tick);
      chk($sformatf("vec%0d_rem", i), bus.remaining, vt[i].rem);
      check_model();
      advance();
    end

    // Periodic N=2: done at +8, +16, +24, then stop.
    apply(1, 0, 2, 1, 0);
    advance();
    dq.delete();
    for (int j = 0; j < 26; j++) begin
      apply(0, 0, 0, 0, 0);
      if (bus.done) dq.push_back(j);
      advance();
    end
    chk("per_done_count", dq.size(), 3);
    if (dq.size() == 3) begin
      chk("per_done0", dq[0], 8);
      chk("per_done1", dq[1], 16);
      chk("per_done2", dq[2], 24);
    end
    chk("per_busy", bus.busy, 1);
    apply(0, 1, 0, 0, 0);
    advance();
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      apply(0, 0, 0, 0, 0);
      cnt += int'(bus.done) + int'(bus.busy);
      advance();
    end
    chk("stop_quiet", cnt, 0);

    // Retrigger at cycle 10 of a N=5 run: only the new N=1 expiry fires.
    apply(1, 0, 5, 0, 0);
    advance();
    for (int j = 0; j < 9; j++) begin
      apply(0, 0, 0, 0, 0);
      advance();
    end
    apply(1, 0, 1, 0, 0);
    advance();
    dq.delete();
    for (int j = 0; j < 24; j++) begin
      apply(0, 0, 0, 0, 0);
      if (bus.done) dq.push_back(j);
      advance();
    end
    chk("retrig_done_count", dq.size(), 1);
    if (dq.size() == 1) chk("retrig_done_at", dq[0], 4);

    // Start and stop together, from IDLE and from RUN.
    apply(1, 1, 3, 0, 0);
    advance();
    apply(0, 0, 0, 0, 0);
    chk("ss_idle_busy", bus.busy, 0);
    advance();
    apply(1, 0, 3, 0, 0);
    advance();
    apply(0, 0, 0, 0, 0);
    advance();
    apply(1, 1, 2, 1, 0);
    advance();
    cnt = 0;
    for (int j = 0; j < 16; j++) begin
      apply(0, 0, 0, 0, 0);
      cnt += int'(bus.done) + int'(bus.busy);
      advance();
    end
    chk("ss_run_quiet", cnt, 0);

`ifdef TICK_TIMER_IRQ_EN
    apply(1, 0, 1, 0, 0);
    advance();
    for (int j = 0; j < 8; j++) begin
      apply(0, 0, 0, 0, 0);
      if (j < 4) chk("irq_low", bus.irq, 0);
      else chk("irq_hold", bus.irq, 1);
      advance();
    end
    apply(0, 0, 0, 0, 1);
    advance();
    apply(0, 0, 0, 0, 0);
    chk("irq_acked", bus.irq, 0);
    advance();
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      apply(($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0),
            8'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0));
      advance();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
